pipe_scroller: RTL

Obstacle generator and collision detector for the Flappy Bird game. It scrolls a field of pipe columns across the LED matrix toward the bird's column, and inserts a new pipe with a pseudo-random gap at a fixed spacing. It compares column 0 against the one-hot bird row from the bird logic stage and drives that stage's `Dead` input. It also keeps the score.

---
 rtl/flappy_pkg.sv | 15 +
 rtl/gap_lfsr.sv | 30 +++
 rtl/pipe_scroller.sv | 102 ++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared constants and types for the Flappy Bird game stages.
package flappy_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic {
    RUN  = 1'b0,
    OVER = 1'b1
  } state_t;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/gap_lfsr.sv
// 8-bit Fibonacci LFSR choosing the lowest open row of each new pipe.
module gap_lfsr #(
  parameter int         ROWS = 8,
  parameter int         GAP  = 3,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] gap_base
);
  import flappy_pkg::*;

  localparam logic [7:0] SLOTS = 8'(ROWS - GAP + 1);

  logic [7:0] lfsr;
  logic       feedback;

  assign feedback = ^(lfsr & LFSR_TAPS);
  assign gap_base = lfsr % SLOTS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= {lfsr[6:0], feedback};
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls pipe columns toward the bird, detects collisions and keeps score.
module pipe_scroller #(
  parameter int         ROWS         = flappy_pkg::ROWS,
  parameter int         COLS         = flappy_pkg::COLS,
  parameter int         GAP          = 3,
  parameter int         SPACING      = 4,
  parameter int         SCROLL_TICKS = 4,
  parameter logic [7:0] SEED         = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [ROWS-1:0]           bird,
  input  logic                      bird_dead,
  output logic [COLS-1:0][ROWS-1:0] pipes,
  output logic                      Dead,
  output logic [7:0]                score,
  output logic                      passed
);
  import flappy_pkg::*;

  localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam int PW = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam logic [SW-1:0] SCROLL_LAST  = SW'(SCROLL_TICKS - 1);
  localparam logic [PW-1:0] SPACING_LAST = PW'(SPACING - 1);

  state_t          state;
  logic [SW-1:0]   scroll_cnt;
  logic [PW-1:0]   spacing_cnt;
  logic [7:0]      gap_base;
  int unsigned     gap_lo;
  logic [ROWS-1:0] new_col;
  logic            hit;
  logic            shift;
  logic            advance;

  assign hit     = |(bird & pipes[0]);
  assign shift   = (state == RUN) && tick && (scroll_cnt == SCROLL_LAST);
  assign advance = shift && (spacing_cnt == '0);
  assign gap_lo  = 32'(gap_base);

  gap_lfsr #(
    .ROWS (ROWS),
    .GAP  (GAP),
    .SEED (SEED)
  ) u_gap_lfsr (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .gap_base (gap_base)
  );

  always_comb begin
    new_col = '0;
    if (spacing_cnt == '0) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        new_col[r] = !((r >= gap_lo) && (r < gap_lo + GAP));
      end
    end
  end

  // A collision or bird_dead on a shift edge still lets that shift land;
  // only the point for the column leaving the field is withheld.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      scroll_cnt  <= '0;
      spacing_cnt <= '0;
      pipes       <= '0;
      Dead        <= 1'b0;
      score       <= '0;
      passed      <= 1'b0;
    end else begin
      passed <= 1'b0;
      if (state == RUN) begin
        if (tick) begin
          scroll_cnt <= (scroll_cnt == SCROLL_LAST) ? '0 : scroll_cnt + 1'b1;
        end
        if (shift) begin
          for (int unsigned i = 0; i < COLS - 1; i++) begin
            pipes[i] <= pipes[i+1];
          end
          pipes[COLS-1] <= new_col;
          spacing_cnt   <= (spacing_cnt == SPACING_LAST) ? '0 : spacing_cnt + 1'b1;
          if ((pipes[0] != '0) && !hit && !bird_dead) begin
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
            passed <= 1'b1;
          end
        end
        if (hit) begin
          Dead <= 1'b1;
        end
        if (hit || bird_dead) begin
          state <= OVER;
        end
      end
    end
  end

endmodule
